// File: rtl/dram_sched_pkg.sv
// Shared command encodings and scheduler state type for dram_bank_sched.
package dram_sched_pkg;

    localparam logic [1:0] CMD_ACT = 2'b00;
    localparam logic [1:0] CMD_RW  = 2'b01;
    localparam logic [1:0] CMD_PRE = 2'b10;
    localparam logic [1:0] CMD_REF = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        ACT,
        RW,
        PRE_ALL,
        REF
    } state_t;

endpackage

// File: rtl/dram_refresh_timer.sv
// Free-running refresh down-counter; raises pending on expiry, sticky miss on expiry while still pending.
module dram_refresh_timer #(
    parameter int REFRESH_INTERVAL = 1024
) (
    input  logic clk,
    input  logic rst_b,
    input  logic clr,
    output logic pending,
    output logic miss
);

    localparam int TW = $clog2(REFRESH_INTERVAL);
    localparam logic [TW-1:0] RELOAD = TW'(REFRESH_INTERVAL - 1);

    logic [TW-1:0] count_reg;
    logic          pending_reg;
    logic          miss_reg;
    logic          expire;

    assign expire = (count_reg == '0);

    // An expiry in the same cycle as the REF ack re-arms pending and is not a miss.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            count_reg   <= RELOAD;
            pending_reg <= 1'b0;
            miss_reg    <= 1'b0;
        end else begin
            count_reg   <= expire ? RELOAD : count_reg - TW'(1);
            pending_reg <= expire | (pending_reg & ~clr);
            if (expire && pending_reg && !clr) begin
                miss_reg <= 1'b1;
            end
        end
    end

    assign pending = pending_reg;
    assign miss    = miss_reg;

endmodule

// File: rtl/dram_bank_sched.sv
// Per-bank DRAM command scheduler with open-row tracking and refresh insertion.
// Define DRAM_SCHED_AUTO_PRECHARGE_EN for close-page operation (PRECHARGE after every READ/WRITE).
module dram_bank_sched
    import dram_sched_pkg::*;
#(
    parameter int NUM_OF_BANKS     = 8,
    parameter int NUM_OF_ROWS      = 128,
    parameter int NUM_OF_COLS      = 8,
    parameter int REFRESH_INTERVAL = 1024
) (
    input  logic                            clk,
    input  logic                            rst_b,
    input  logic                            req_val,
    output logic                            req_rdy,
    input  logic                            req_rw,
    input  logic [$clog2(NUM_OF_BANKS)-1:0] req_bank_id,
    input  logic [$clog2(NUM_OF_ROWS)-1:0]  req_row_id,
    input  logic [$clog2(NUM_OF_COLS)-1:0]  req_col_id,
    output logic                            cmd_req,
    input  logic                            cmd_ack,
    output logic [1:0]                      cmd,
    output logic [$clog2(NUM_OF_BANKS)-1:0] cmd_bank_id,
    output logic [$clog2(NUM_OF_ROWS)-1:0]  cmd_row_id,
    output logic [$clog2(NUM_OF_COLS)-1:0]  cmd_col_id,
    output logic                            bank_rw,
    output logic                            done,
    output logic                            refresh_busy,
    output logic                            refresh_miss
);

    localparam int BW  = $clog2(NUM_OF_BANKS);
    localparam int RWD = $clog2(NUM_OF_ROWS);
    localparam int CWD = $clog2(NUM_OF_COLS);

    state_t           state_reg, state_next;
    logic             gap_reg, gap_next;
    logic             started_reg;
    logic             done_reg, done_next;
    logic [BW-1:0]    lat_bank_reg;
    logic [RWD-1:0]   lat_row_reg;
    logic [CWD-1:0]   lat_col_reg;
    logic             lat_rw_reg;
    logic             open_reg [NUM_OF_BANKS];
    logic [RWD-1:0]   row_reg  [NUM_OF_BANKS];
    logic             any_open;
    logic [BW-1:0]    first_open;
    logic             accept, set_open, clr_open, ref_clr;
    logic [BW-1:0]    clr_bank;
    logic             ref_pending, ref_miss;
    logic             cmd_req_int, ack;
    logic [1:0]       cmd_sel;
    logic [BW-1:0]    sel_bank;
    logic [RWD-1:0]   sel_row;
    logic [CWD-1:0]   sel_col;
    logic             sel_rw;
`ifdef DRAM_SCHED_AUTO_PRECHARGE_EN
    logic             post_rw_reg, post_rw_next;
`endif

    dram_refresh_timer #(
        .REFRESH_INTERVAL(REFRESH_INTERVAL)
    ) u_refresh_timer (
        .clk    (clk),
        .rst_b  (rst_b),
        .clr    (ref_clr),
        .pending(ref_pending),
        .miss   (ref_miss)
    );

    // Lowest-numbered open bank drives the precharge-all scan.
    always_comb begin
        any_open   = 1'b0;
        first_open = '0;
        for (int i = NUM_OF_BANKS - 1; i >= 0; i--) begin
            if (open_reg[i]) begin
                any_open   = 1'b1;
                first_open = BW'(i);
            end
        end
    end

    always_comb begin
        cmd_req_int = 1'b0;
        cmd_sel     = CMD_ACT;
        sel_bank    = '0;
        sel_row     = '0;
        sel_col     = '0;
        sel_rw      = 1'b0;
        case (state_reg)
            PRE: begin
                cmd_req_int = !gap_reg;
                cmd_sel     = CMD_PRE;
                sel_bank    = lat_bank_reg;
            end
            ACT: begin
                cmd_req_int = !gap_reg;
                cmd_sel     = CMD_ACT;
                sel_bank    = lat_bank_reg;
                sel_row     = lat_row_reg;
            end
            RW: begin
                cmd_req_int = !gap_reg;
                cmd_sel     = CMD_RW;
                sel_bank    = lat_bank_reg;
                sel_row     = lat_row_reg;
                sel_col     = lat_col_reg;
                sel_rw      = lat_rw_reg;
            end
            PRE_ALL: begin
                cmd_req_int = any_open && !gap_reg;
                cmd_sel     = CMD_PRE;
                sel_bank    = first_open;
            end
            REF: begin
                cmd_req_int = !gap_reg;
                cmd_sel     = CMD_REF;
            end
            default: ;
        endcase
    end

    assign ack     = cmd_ack && cmd_req_int;
    assign req_rdy = started_reg && (state_reg == IDLE) && !ref_pending;
    assign accept  = req_val && req_rdy;

    // gap_next is raised on every ack that leads to another command, forcing one idle cycle.
    always_comb begin
        state_next = state_reg;
        gap_next   = 1'b0;
        done_next  = 1'b0;
        set_open   = 1'b0;
        clr_open   = 1'b0;
        clr_bank   = lat_bank_reg;
        ref_clr    = 1'b0;
`ifdef DRAM_SCHED_AUTO_PRECHARGE_EN
        post_rw_next = post_rw_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (ref_pending) begin
                    state_next = PRE_ALL;
                end else if (accept) begin
`ifdef DRAM_SCHED_AUTO_PRECHARGE_EN
                    post_rw_next = 1'b0;
`endif
                    if (!open_reg[req_bank_id]) begin
                        state_next = ACT;
                    end else if (row_reg[req_bank_id] == req_row_id) begin
                        state_next = RW;
                    end else begin
                        state_next = PRE;
                    end
                end
            end
            PRE: begin
                if (ack) begin
                    clr_open = 1'b1;
                    gap_next = 1'b1;
`ifdef DRAM_SCHED_AUTO_PRECHARGE_EN
                    state_next = post_rw_reg ? IDLE : ACT;
`else
                    state_next = ACT;
`endif
                end
            end
            ACT: begin
                if (ack) begin
                    set_open   = 1'b1;
                    gap_next   = 1'b1;
                    state_next = RW;
                end
            end
            RW: begin
                if (ack) begin
                    done_next = 1'b1;
`ifdef DRAM_SCHED_AUTO_PRECHARGE_EN
                    post_rw_next = 1'b1;
                    gap_next     = 1'b1;
                    state_next   = PRE;
`else
                    state_next = IDLE;
`endif
                end
            end
            PRE_ALL: begin
                if (!any_open) begin
                    state_next = REF;
                end else if (ack) begin
                    clr_open = 1'b1;
                    clr_bank = first_open;
                    gap_next = 1'b1;
                end
            end
            REF: begin
                if (ack) begin
                    ref_clr    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_reg    <= IDLE;
            gap_reg      <= 1'b0;
            started_reg  <= 1'b0;
            done_reg     <= 1'b0;
            lat_bank_reg <= '0;
            lat_row_reg  <= '0;
            lat_col_reg  <= '0;
            lat_rw_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            gap_reg     <= gap_next;
            started_reg <= 1'b1;
            done_reg    <= done_next;
            if (accept) begin
                lat_bank_reg <= req_bank_id;
                lat_row_reg  <= req_row_id;
                lat_col_reg  <= req_col_id;
                lat_rw_reg   <= req_rw;
            end
        end
    end

`ifdef DRAM_SCHED_AUTO_PRECHARGE_EN
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            post_rw_reg <= 1'b0;
        end else begin
            post_rw_reg <= post_rw_next;
        end
    end
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM_OF_BANKS; gi++) begin : g_bank
            always_ff @(posedge clk or negedge rst_b) begin
                if (!rst_b) begin
                    open_reg[gi] <= 1'b0;
                    row_reg[gi]  <= '0;
                end else if (set_open && lat_bank_reg == BW'(gi)) begin
                    open_reg[gi] <= 1'b1;
                    row_reg[gi]  <= lat_row_reg;
                end else if (clr_open && clr_bank == BW'(gi)) begin
                    open_reg[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    assign cmd_req      = cmd_req_int;
    assign cmd          = cmd_req_int ? cmd_sel  : 2'b00;
    assign cmd_bank_id  = cmd_req_int ? sel_bank : '0;
    assign cmd_row_id   = cmd_req_int ? sel_row  : '0;
    assign cmd_col_id   = cmd_req_int ? sel_col  : '0;
    assign bank_rw      = cmd_req_int && sel_rw;
    assign done         = done_reg;
    assign refresh_busy = ref_pending;
    assign refresh_miss = ref_miss;

endmodule
